// File: rtl/fork_join_ctrl_pkg.sv
// Shared types and join-policy helpers for the fork/join barrier controller.
// Optional timeout support is enabled with the FORK_JOIN_TIMEOUT_EN macro.
package fork_join_pkg;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2,
    JOIN_RSVD = 2'd3
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    WAIT     = 2'd2,
    DRAIN    = 2'd3
  } fj_state_e;

  localparam int unsigned MAX_CHILD = 8;

  function automatic logic all_done(logic [MAX_CHILD-1:0] mask, int n_child);
    logic [MAX_CHILD:0]   lim;
    logic [MAX_CHILD-1:0] full;
    lim  = {{MAX_CHILD{1'b0}}, 1'b1} << n_child;
    full = MAX_CHILD'(lim - 1'b1);
    return mask == full;
  endfunction

  // Reserved encoding behaves as ALL.
  function automatic logic join_met(join_mode_e mode, logic [MAX_CHILD-1:0] mask,
                                    int n_child);
    case (mode)
      JOIN_ANY:  return |mask;
      JOIN_NONE: return 1'b1;
      default:   return all_done(mask, n_child);
    endcase
  endfunction

endpackage

// File: rtl/fork_join_ctrl_if.sv
// Parent/child handshake bundle for fork_join_ctrl; master = stimulus side, slave = controller.
// Timeout signals exist only when FORK_JOIN_TIMEOUT_EN is defined.
interface fork_join_ctrl_if #(
  parameter int N_CHILD = 3,
  parameter int TS_W    = 16
`ifdef FORK_JOIN_TIMEOUT_EN
  , parameter int TMO_W = 8
`endif
) ();
  localparam int ID_W = $clog2(N_CHILD);

  logic               start_i;
  logic [1:0]         mode_i;
  logic [N_CHILD-1:0] done_i;
  logic [N_CHILD-1:0] go_o;
  logic               busy_o;
  logic               proceed_o;
  logic [N_CHILD-1:0] done_mask_o;
  logic [ID_W-1:0]    first_id_o;
  logic [TS_W-1:0]    proceed_ts_o;
`ifdef FORK_JOIN_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_limit_i;
  logic               timeout_o;
`endif

  modport master (
    output start_i, mode_i, done_i,
    input  go_o, busy_o, proceed_o, done_mask_o, first_id_o, proceed_ts_o
`ifdef FORK_JOIN_TIMEOUT_EN
    , output tmo_limit_i
    , input  timeout_o
`endif
  );

  modport slave (
    input  start_i, mode_i, done_i,
    output go_o, busy_o, proceed_o, done_mask_o, first_id_o, proceed_ts_o
`ifdef FORK_JOIN_TIMEOUT_EN
    , input  tmo_limit_i
    , output timeout_o
`endif
  );

endinterface

// File: rtl/fork_join_ctrl_done_tracker.sv
// Sticky per-child completion mask with first-finisher capture (lowest index wins ties).
// Used by fork_join_ctrl; no configuration macros.
module fj_done_tracker
  import fork_join_pkg::*;
#(
  parameter int N_CHILD = 3,
  localparam int ID_W = $clog2(N_CHILD)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic [N_CHILD-1:0] done_i,
  output logic [N_CHILD-1:0] mask_o,
  output logic [N_CHILD-1:0] mask_upd_o,
  output logic [ID_W-1:0]    first_id_o
);

  logic [ID_W-1:0] low_id;

  always_comb begin
    mask_upd_o = mask_o | done_i;
    low_id     = '0;
    for (int unsigned i = N_CHILD; i > 0; i--) begin
      if (done_i[i-1]) low_id = ID_W'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      mask_o     <= '0;
      first_id_o <= '0;
    end else if (en_i) begin
      mask_o <= mask_upd_o;
      if (mask_o == '0 && done_i != '0) first_id_o <= low_id;
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join barrier: one go pulse to all children, proceed under ALL/ANY/NONE policy, busy until all report.
// Define FORK_JOIN_TIMEOUT_EN to add tmo_limit_i/timeout_o and the watchdog counter.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N_CHILD = 3,
  parameter int TS_W    = 16,
  parameter int TMO_W   = 8
) (
  input logic           clk,
  input logic           rst,
  fork_join_ctrl_if.slave bus
);

  fj_state_e          state, state_nxt;
  join_mode_e         mode_q;
  logic [TS_W-1:0]    ts;
  logic [N_CHILD-1:0] mask_upd;
  logic               accept, track_en, full_upd, met, fire;

  assign accept   = (state == IDLE) && bus.start_i;
  assign track_en = (state != IDLE);
  assign full_upd = all_done(MAX_CHILD'(mask_upd), N_CHILD);
  assign met      = join_met(mode_q, MAX_CHILD'(mask_upd), N_CHILD);

  fj_done_tracker #(.N_CHILD(N_CHILD)) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .en_i       (track_en),
    .done_i     (bus.done_i),
    .mask_o     (bus.done_mask_o),
    .mask_upd_o (mask_upd),
    .first_id_o (bus.first_id_o)
  );

`ifdef FORK_JOIN_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt, tmo_inc;
  logic             tmo_hit;

  assign tmo_inc = tmo_cnt + 1'b1;
  // A fork whose children all report this cycle completes normally instead of timing out.
  assign tmo_hit = (state == WAIT || state == DRAIN) && (bus.tmo_limit_i != '0) &&
                   (tmo_inc == bus.tmo_limit_i) && !full_upd;
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
`endif

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      IDLE:     if (bus.start_i) state_nxt = DISPATCH;
      DISPATCH,
      WAIT: begin
        if (met) begin
          fire      = 1'b1;
          state_nxt = full_upd ? IDLE : DRAIN;
        end else begin
          state_nxt = WAIT;
        end
      end
      DRAIN:    if (full_upd) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
`ifdef FORK_JOIN_TIMEOUT_EN
    if (tmo_hit) begin
      state_nxt = IDLE;
      fire      = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      mode_q           <= JOIN_ALL;
      ts               <= '0;
      bus.go_o         <= '0;
      bus.busy_o       <= 1'b0;
      bus.proceed_o    <= 1'b0;
      bus.proceed_ts_o <= '0;
    end else begin
      state         <= state_nxt;
      ts            <= ts + 1'b1;
      bus.go_o      <= accept ? '1 : '0;
      bus.busy_o    <= (state_nxt != IDLE);
      bus.proceed_o <= fire;
      if (accept) mode_q <= join_mode_e'(bus.mode_i);
      // Captured value equals the timestamp of the cycle proceed_o is high.
      if (fire) bus.proceed_ts_o <= ts + 1'b1;
    end
  end

`ifdef FORK_JOIN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt       <= '0;
      bus.timeout_o <= 1'b0;
    end else begin
      bus.timeout_o <= tmo_hit;
      if (state == DISPATCH)                    tmo_cnt <= '0;
      else if (state == WAIT || state == DRAIN) tmo_cnt <= tmo_inc;
    end
  end
`endif

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Randomized bench for fork_join_ctrl; expectations come from per-fork completion offsets.
// Timeout scenario is exercised only when FORK_JOIN_TIMEOUT_EN is defined.
module tb_fork_join_ctrl;

  localparam int NC  = 3;
  localparam int TSW = 16;
  localparam logic [31:0] ALL1 = (32'd1 << NC) - 32'd1;

  logic clk = 1'b0;
  logic rst;

  fork_join_ctrl_if #(
    .N_CHILD(NC),
    .TS_W   (TSW)
`ifdef FORK_JOIN_TIMEOUT_EN
    , .TMO_W(8)
`endif
  ) bus ();

  fork_join_ctrl #(.N_CHILD(NC), .TS_W(TSW), .TMO_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [TSW-1:0] ts_model;
  always @(posedge clk) begin
    if (rst) ts_model <= '0;
    else     ts_model <= ts_model + 1'b1;
  end

  int unsigned    n_checks = 0;
  int unsigned    n_errors = 0;
  logic [NC-1:0]  exp_mask;
  logic [1:0]     exp_first;
  logic [TSW-1:0] exp_pts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input bit e_go, input bit e_busy, input bit e_proc);
    check($sformatf("%s.go", tag),      32'(bus.go_o),         e_go ? ALL1 : 32'd0);
    check($sformatf("%s.busy", tag),    32'(bus.busy_o),       32'(e_busy));
    check($sformatf("%s.proceed", tag), 32'(bus.proceed_o),    32'(e_proc));
    check($sformatf("%s.mask", tag),    32'(bus.done_mask_o),  32'(exp_mask));
    check($sformatf("%s.first", tag),   32'(bus.first_id_o),   32'(exp_first));
    check($sformatf("%s.pts", tag),     32'(bus.proceed_ts_o), 32'(exp_pts));
  endtask

  // off[i]: cycles after dispatch at which child i first reports. Start is cycle k=0.
  task automatic run_fork(input string tag, input int mode, input int off [NC],
                          input bit hold, input int rst_at);
    int mx, mn, p, fid;
    logic [NC-1:0] d;
    mx = 0;
    mn = 1000;
    for (int i = 0; i < NC; i++) begin
      if (off[i] > mx) mx = off[i];
      if (off[i] < mn) mn = off[i];
    end
    fid = 0;
    for (int i = NC - 1; i >= 0; i--) if (off[i] == mn) fid = i;
    case (mode)
      1:       p = 2 + mn;
      2:       p = 2;
      default: p = 2 + mx;
    endcase
    for (int k = 0; k <= 2 + mx; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        exp_mask = '0;
        for (int i = 0; i < NC; i++) if (off[i] <= k - 2) exp_mask[i] = 1'b1;
      end
      if (k == 1)      exp_first = '0;
      if (k == 2 + mn) exp_first = 2'(fid);
      if (k == p)      exp_pts = ts_model;
      check_outputs(tag, k == 1, (k >= 1) && (k <= 1 + mx), k == p);
      if (k == rst_at) begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.done_i  = '0;
        @(negedge clk);
        exp_mask  = '0;
        exp_first = '0;
        exp_pts   = '0;
        check_outputs($sformatf("%s.rst", tag), 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        bus.done_i = '1;
        return;
      end
      bus.start_i = (k == 0) || ((k <= 1 + mx) && (hold || $urandom_range(0, 3) == 0));
      bus.mode_i  = (k == 0) ? 2'(mode) : 2'($urandom_range(0, 3));
      d = '0;
      for (int i = 0; i < NC; i++) begin
        if (k == 1 + off[i])
          d[i] = 1'b1;
        else if (k > 1 + off[i] && k <= 1 + mx && ((hold && i == 0) || $urandom_range(0, 3) == 0))
          d[i] = 1'b1;
        else if ((k == 0 || k == 2 + mx) && $urandom_range(0, 3) == 0)
          d[i] = 1'b1;
      end
      bus.done_i = d;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_outputs("idle", 1'b0, 1'b0, 1'b0);
      bus.start_i = 1'b0;
      bus.done_i  = NC'($urandom_range(0, (1 << NC) - 1));
    end
  endtask

  initial begin
    int roff [NC];
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.mode_i  = '0;
    bus.done_i  = '0;
`ifdef FORK_JOIN_TIMEOUT_EN
    bus.tmo_limit_i = '0;
`endif
    repeat (3) @(negedge clk);
    exp_mask  = '0;
    exp_first = '0;
    exp_pts   = '0;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    run_fork("all",       0, '{2, 7, 4}, 1'b0, -1);
    run_fork("any",       1, '{6, 3, 3}, 1'b0, -1);
    run_fork("none",      2, '{5, 5, 5}, 1'b0, -1);
    run_fork("hold",      0, '{0, 3, 5}, 1'b1, -1);
    run_fork("rstmid",    0, '{1, 2, 9}, 1'b0, 4);
    run_fork("after_rst", 0, '{0, 0, 0}, 1'b0, -1);
    run_fork("rsvd",      3, '{4, 1, 2}, 1'b0, -1);

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NC; i++) roff[i] = int'($urandom_range(0, 6));
      run_fork($sformatf("rand%0d", t), int'($urandom_range(0, 3)), roff,
               ($urandom_range(0, 4) == 0), -1);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end

`ifdef FORK_JOIN_TIMEOUT_EN
    begin
      bit saw_t, saw_p;
      saw_t = 1'b0;
      saw_p = 1'b0;
      @(negedge clk);
      bus.tmo_limit_i = 8'd5;
      bus.start_i     = 1'b1;
      bus.mode_i      = 2'd0;
      bus.done_i      = '0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (bus.timeout_o === 1'b1) saw_t = 1'b1;
        if (bus.proceed_o === 1'b1) saw_p = 1'b1;
        bus.start_i = 1'b0;
        bus.done_i  = (k == 1) ? NC'(1) : '0;
      end
      check("tmo.seen",    32'(saw_t), 32'd1);
      check("tmo.proceed", 32'(saw_p), 32'd0);
      check("tmo.mask",    32'(bus.done_mask_o), 32'd1);
      check("tmo.busy",    32'(bus.busy_o), 32'd0);
      bus.tmo_limit_i = '0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
- Hardware fork/join barrier for the practice-code stimulus layer.
- On `start_i`, issues one `go` pulse to N parallel child engines, then collects their completion pulses.
- Releases the parent, via a `proceed_o` pulse, under a selectable join policy: ALL (join), ANY (join_any), NONE (join_none).
- Tracks still-running children after release (the `wait fork` equivalent) and holds `busy_o` until every child has reported.

Parameters:
- N_CHILD, 3, number of child engines (2..8).
- TS_W, 16, width of the free-running cycle timestamp.
- TMO_W, 8, width of the timeout counter (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request to fork; accepted only in IDLE.
- mode_i  in  2  join policy, sampled with start_i: 0=ALL, 1=ANY, 2=NONE, 3=reserved (treated as ALL).
- done_i  in  N_CHILD  per-child completion pulse, one cycle each.
- go_o  out  N_CHILD  fork pulse; all bits high for exactly one cycle.
- busy_o  out  1  high from start acceptance until all children are done.
- proceed_o  out  1  one-cycle parent-release pulse.
- done_mask_o  out  N_CHILD  sticky record of children done in the current fork.
- first_id_o  out  $clog2(N_CHILD)  index of the first child to complete.
- proceed_ts_o  out  TS_W  timestamp captured when proceed_o fires.

Behaviour:
- All outputs are registered.
- Reset values: go_o=0, busy_o=0, proceed_o=0, done_mask_o=0, first_id_o=0, proceed_ts_o=0, state=IDLE, timestamp=0.
- Timestamp: free-running, increments every cycle, wraps modulo 2^TS_W.
- States: IDLE, DISPATCH, WAIT, DRAIN.
- IDLE:
  - start_i=1 at cycle c latches mode and clears done_mask_o and first_id_o.
  - Next state is DISPATCH; busy_o=1 from c+1.
  - done_i is ignored in IDLE.
- DISPATCH (one cycle, c+1):
  - go_o = all ones.
  - done_i is sampled from this cycle on, since combinational children are allowed.
  - Next state is WAIT.
- Mask update, in DISPATCH/WAIT/DRAIN: done_mask_o |= done_i.
  - A repeated pulse from an already-done child has no effect.
  - first_id_o is set on the first cycle the mask goes nonzero.
  - If several children finish in that same cycle, first_id_o takes the lowest index.
- Join condition, evaluated on the updated mask:
  - ALL: mask is all ones.
  - ANY: mask is nonzero.
  - NONE: true from DISPATCH regardless of done_i.
- proceed_o:
  - Asserted the cycle after the condition first becomes true; NONE therefore fires at c+2.
  - Fires exactly once per fork; proceed_ts_o captures the timestamp in the same cycle.
- After the condition is met:
  - If the mask is all ones, the next state is IDLE and busy_o drops with proceed_o.
  - Otherwise the next state is DRAIN.
- DRAIN: stay until the mask is all ones, then go to IDLE; busy_o deasserts the cycle after.
- start_i while busy_o=1 is ignored; it is not queued.
- rst mid-operation: immediate return to reset values; no proceed_o is emitted.

Optional Feature:
- Macro: FORK_JOIN_TIMEOUT_EN.
- Enabled:
  - Adds input tmo_limit_i (TMO_W) and output timeout_o (1).
  - A counter starts at DISPATCH and counts every cycle in WAIT/DRAIN.
  - When the count equals tmo_limit_i, timeout_o pulses one cycle and the state returns to IDLE; busy_o drops the same cycle.
  - If proceed_o has not yet fired, it is never emitted for that fork.
  - done_mask_o holds its value for debug.
  - tmo_limit_i=0 disables the timeout.
- Disabled: no such ports or counter; the block waits indefinitely.

Decomposition:
- Package fork_join_pkg holds:
  - typedef enum join_mode_e {JOIN_ALL, JOIN_ANY, JOIN_NONE, JOIN_RSVD};
  - typedef enum fj_state_e {IDLE, DISPATCH, WAIT, DRAIN};
  - function join_met(mode, mask).
- One natural sub-module: fj_done_tracker, which holds the sticky mask, first-completion detect and lowest-index priority encoder.

Test Plan:
- ALL, N=3: start at cycle 0, done_i=001 @3, 100 @5, 010 @8 -> proceed_o @9, first_id_o=0, busy_o low @9, proceed_ts_o=9.
- ANY: start @0, done_i=110 @4 -> proceed_o @5, first_id_o=1; done_i=001 @7 -> busy_o low @8, no second proceed.
- NONE: start @0, no done_i -> go_o=111 @1, proceed_o @2, busy_o stays high; done_i=111 @6 -> busy_o low @7.
- start_i held high with a repeated done_i=001 pulse in ALL mode -> single go_o pulse, mask=001 unchanged, no proceed until 111.
- rst asserted @4 mid-WAIT with mask=011 -> @5 all outputs at reset values; later done_i is ignored; a new start @6 gives go_o @7.
- With FORK_JOIN_TIMEOUT_EN, tmo_limit_i=5, ALL, only done_i=001 -> timeout_o pulses, no proceed_o, done_mask_o=001, returns to IDLE.
